// File: rtl/insn_decode_stage.sv
// Registered decode stage: full base opcode decode, field/immediate extraction,
// valid/ready pipeline register and load-use bubble (enabled by DECODER_HAZARD_EN).
module insn_decode_stage #(
    parameter int unsigned INSN_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned RZERO_SKIP = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [INSN_W-1:0] in_insn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_ctrl,
    output logic [4:0]        out_alu_op,
    output logic [4:0]        out_shamt,
    output logic [REG_AW-1:0] out_rd,
    output logic [REG_AW-1:0] out_rs,
    output logic [REG_AW-1:0] out_rt,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_target,
    output logic              out_illegal
);

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned OP_W   = 5;
    localparam int unsigned ALU_W  = 5;
    localparam int unsigned IMM_W  = 17;
    localparam int unsigned TGT_W  = 27;

    localparam logic [OP_W-1:0] OP_R    = 5'd0;
    localparam logic [OP_W-1:0] OP_J    = 5'd1;
    localparam logic [OP_W-1:0] OP_BNE  = 5'd2;
    localparam logic [OP_W-1:0] OP_JAL  = 5'd3;
    localparam logic [OP_W-1:0] OP_JR   = 5'd4;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd5;
    localparam logic [OP_W-1:0] OP_BLT  = 5'd6;
    localparam logic [OP_W-1:0] OP_SW   = 5'd7;
    localparam logic [OP_W-1:0] OP_LW   = 5'd8;

    // Control vector bit positions: {BR, JP, ALUinB, ALUop, DMwe, Rwe, Rdst, Rwd}
    localparam logic [CTRL_W-1:0] C_BR     = 8'h80;
    localparam logic [CTRL_W-1:0] C_JP     = 8'h40;
    localparam logic [CTRL_W-1:0] C_ALUINB = 8'h20;
    localparam logic [CTRL_W-1:0] C_ALUOP  = 8'h10;
    localparam logic [CTRL_W-1:0] C_DMWE   = 8'h08;
    localparam logic [CTRL_W-1:0] C_RWE    = 8'h04;
    localparam logic [CTRL_W-1:0] C_RDST   = 8'h02;
    localparam logic [CTRL_W-1:0] C_RWD    = 8'h01;

    localparam logic [ALU_W-1:0] ALU_SUB = 5'd1;

    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] f_rd, f_rs, f_rt;
    logic [ALU_W-1:0]  f_shamt, f_aluop;
    logic [DATA_W-1:0] f_imm, f_target;

    assign opcode   = in_insn[31:27];
    assign f_rd     = REG_AW'(in_insn[26:22]);
    assign f_rs     = REG_AW'(in_insn[21:17]);
    assign f_rt     = REG_AW'(in_insn[16:12]);
    assign f_shamt  = in_insn[11:7];
    assign f_aluop  = in_insn[6:2];
    assign f_imm    = {{(DATA_W-IMM_W){in_insn[16]}}, in_insn[16:0]};
    assign f_target = {{(DATA_W-TGT_W){1'b0}}, in_insn[26:0]};

    logic [CTRL_W-1:0] dec_ctrl;
    logic [ALU_W-1:0]  dec_alu_op;
    logic              dec_illegal;

    // Opcode to control vector / ALU operation
    always_comb begin
        dec_ctrl    = '0;
        dec_alu_op  = '0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_R:    begin dec_ctrl = C_RWE; dec_alu_op = f_aluop; end
            OP_J:    dec_ctrl = C_JP;
            OP_BNE:  begin dec_ctrl = C_BR | C_ALUOP; dec_alu_op = ALU_SUB; end
            OP_JAL:  dec_ctrl = C_JP | C_RWE | C_RDST;
            OP_JR:   dec_ctrl = C_JP;
            OP_ADDI: dec_ctrl = C_ALUINB | C_RWE;
            OP_BLT:  begin dec_ctrl = C_BR | C_ALUOP; dec_alu_op = ALU_SUB; end
            OP_SW:   dec_ctrl = C_ALUINB | C_DMWE;
            OP_LW:   dec_ctrl = C_ALUINB | C_RWE | C_RWD;
            default: dec_illegal = 1'b1;
        endcase
    end

    logic hazard;
    logic load;

    assign in_ready = flush | ((out_ready | ~out_valid) & ~hazard);
    assign load     = in_valid & in_ready & ~flush;

`ifdef DECODER_HAZARD_EN
    typedef enum logic {S_RUN, S_BUBBLE} state_t;

    state_t state;
    logic   held_lw;
    logic   read_rd, read_rs, read_rt;
    logic   hit_rd, hit_rs, hit_rt;
    logic   skip_zero;

    // Source registers read by the incoming instruction
    always_comb begin
        read_rd = 1'b0;
        read_rs = 1'b0;
        read_rt = 1'b0;
        case (opcode)
            OP_R:                 begin read_rs = 1'b1; read_rt = 1'b1; end
            OP_ADDI, OP_LW:       read_rs = 1'b1;
            OP_SW, OP_BNE, OP_BLT: begin read_rd = 1'b1; read_rs = 1'b1; end
            OP_JR:                read_rd = 1'b1;
            default:              ;
        endcase
    end

    assign skip_zero = (RZERO_SKIP != 0);
    assign hit_rd = read_rd && (f_rd == out_rd) && !(skip_zero && f_rd == '0);
    assign hit_rs = read_rs && (f_rs == out_rd) && !(skip_zero && f_rs == '0);
    assign hit_rt = read_rt && (f_rt == out_rd) && !(skip_zero && f_rt == '0);

    assign hazard = (state == S_RUN) && out_valid && held_lw && in_valid
                    && (hit_rd || hit_rs || hit_rt);

    // Bubble sequencing and held-load tracking
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_RUN;
            held_lw <= 1'b0;
        end else if (flush) begin
            state   <= S_RUN;
        end else begin
            if (load) held_lw <= (opcode == OP_LW);
            case (state)
                S_RUN:    if (out_valid && out_ready && hazard) state <= S_BUBBLE;
                S_BUBBLE: state <= S_RUN;
                default:  state <= S_RUN;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{in_insn[1:0]};
`else
    assign hazard = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{in_insn[1:0], 1'(RZERO_SKIP)};
`endif

    // Pipeline register
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_ctrl    <= '0;
            out_alu_op  <= '0;
            out_shamt   <= '0;
            out_rd      <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_imm     <= '0;
            out_target  <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_ctrl    <= dec_ctrl;
            out_alu_op  <= dec_alu_op;
            out_shamt   <= f_shamt;
            out_rd      <= f_rd;
            out_rs      <= f_rs;
            out_rt      <= f_rt;
            out_imm     <= f_imm;
            out_target  <= f_target;
            out_illegal <= dec_illegal;
        end else if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_insn_decode_stage.sv
// Self-checking bench for insn_decode_stage: vector table, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_insn_decode_stage;

`ifdef DECODER_HAZARD_EN
    localparam bit HZ_EN = 1'b1;
`else
    localparam bit HZ_EN = 1'b0;
`endif
    localparam bit RZ_SKIP = 1'b1;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_insn;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_ctrl;
    logic [4:0]  out_alu_op;
    logic [4:0]  out_shamt;
    logic [4:0]  out_rd, out_rs, out_rt;
    logic [31:0] out_imm, out_target;
    logic        out_illegal;

    int checks   = 0;
    int failures = 0;

    insn_decode_stage #(.INSN_W(32), .DATA_W(32), .REG_AW(5), .RZERO_SKIP(1)) dut (
        .clock(clock), .reset(reset), .in_insn(in_insn), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_alu_op(out_alu_op), .out_shamt(out_shamt),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_imm(out_imm),
        .out_target(out_target), .out_illegal(out_illegal)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] insn;
        logic [7:0]  ctrl;
        logic [4:0]  alu_op;
        logic        illegal;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                       input int rt, input int low);
        return {5'(op), 5'(rd), 5'(rs), 5'(rt), 12'(low)};
    endfunction

    // Reference decode straight from the opcode table
    function automatic logic [7:0] m_ctrl(input logic [31:0] i);
        case (int'(i[31:27]))
            0: return 8'h04;
            1: return 8'h40;
            2: return 8'h90;
            3: return 8'h46;
            4: return 8'h40;
            5: return 8'h24;
            6: return 8'h90;
            7: return 8'h28;
            8: return 8'h25;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [4:0] m_alu(input logic [31:0] i);
        int op = int'(i[31:27]);
        if (op == 0) return i[6:2];
        if (op == 2 || op == 6) return 5'd1;
        return 5'd0;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] i);
        int v = int'(i & 32'h1FFFF);
        if (v >= 65536) v = v - 131072;
        return 32'(v);
    endfunction

    function automatic bit m_reads(input logic [31:0] i, input logic [4:0] r);
        int op = int'(i[31:27]);
        logic [4:0] rd = i[26:22];
        logic [4:0] rs = i[21:17];
        logic [4:0] rt = i[16:12];
        if (RZ_SKIP && r == 5'd0) return 1'b0;
        case (op)
            0:       return (rs == r) || (rt == r);
            5, 8:    return rs == r;
            2, 6, 7: return (rd == r) || (rs == r);
            4:       return rd == r;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk_out(input string nm, input logic [31:0] i);
        chk({nm, "_valid"},  32'(out_valid),   32'd1);
        chk({nm, "_ctrl"},   32'(out_ctrl),    32'(m_ctrl(i)));
        chk({nm, "_aluop"},  32'(out_alu_op),  32'(m_alu(i)));
        chk({nm, "_shamt"},  32'(out_shamt),   32'(i[11:7]));
        chk({nm, "_rd"},     32'(out_rd),      32'(i[26:22]));
        chk({nm, "_rs"},     32'(out_rs),      32'(i[21:17]));
        chk({nm, "_rt"},     32'(out_rt),      32'(i[16:12]));
        chk({nm, "_imm"},    out_imm,          m_imm(i));
        chk({nm, "_target"}, out_target,       i & 32'h07FF_FFFF);
        chk({nm, "_ill"},    32'(out_illegal), 32'(i[31:27] > 5'd8));
    endtask

    function automatic logic [31:0] gen();
        int op = ($urandom_range(0, 3) == 0) ? 8 : int'($urandom_range(0, 10));
        if (op >= 9) op = (op == 9) ? 31 : 12;
        return mk(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom));
    endfunction

    logic [31:0] lw_r3, add_r3, lw_r0, add_r0, sw_i, addi_i;
    logic        m_valid;
    logic [31:0] m_insn;
    bit          hz, exp_rdy;

    initial begin
        vecs[0]  = '{mk(0, 1, 2, 3, (7 << 7) | (9 << 2)), 8'h04, 5'd9, 1'b0};
        vecs[1]  = '{mk(1, 4, 5, 6, 9 << 2),              8'h40, 5'd0, 1'b0};
        vecs[2]  = '{mk(2, 1, 2, 0, 9 << 2),              8'h90, 5'd1, 1'b0};
        vecs[3]  = '{mk(3, 7, 0, 0, 12'hFFF),             8'h46, 5'd0, 1'b0};
        vecs[4]  = '{mk(4, 9, 0, 0, 0),                   8'h40, 5'd0, 1'b0};
        vecs[5]  = '{mk(5, 1, 2, 31, 12'h800),            8'h24, 5'd0, 1'b0};
        vecs[6]  = '{mk(6, 3, 4, 0, 9 << 2),              8'h90, 5'd1, 1'b0};
        vecs[7]  = '{mk(7, 5, 6, 1, 12'h010),             8'h28, 5'd0, 1'b0};
        vecs[8]  = '{mk(8, 3, 2, 0, 12'h004),             8'h25, 5'd0, 1'b0};
        vecs[9]  = '{mk(31, 3, 3, 3, 9 << 2),             8'h00, 5'd0, 1'b1};
        vecs[10] = '{mk(9, 1, 1, 1, 0),                   8'h00, 5'd0, 1'b1};

        lw_r3  = mk(8, 3, 2, 0, 0);
        add_r3 = mk(0, 4, 3, 5, 0);
        lw_r0  = mk(8, 0, 2, 0, 0);
        add_r0 = mk(0, 4, 0, 0, 0);
        sw_i   = mk(7, 6, 7, 0, 12'h010);
        addi_i = 32'h2844_0005;

        reset = 1'b1; in_insn = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);   chk("rst_ctrl", 32'(out_ctrl), 0);
        chk("rst_aluop", 32'(out_alu_op), 0);  chk("rst_shamt", 32'(out_shamt), 0);
        chk("rst_rd", 32'(out_rd), 0);         chk("rst_rs", 32'(out_rs), 0);
        chk("rst_rt", 32'(out_rt), 0);         chk("rst_imm", out_imm, 0);
        chk("rst_target", out_target, 0);      chk("rst_ill", 32'(out_illegal), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Single addi decode
        out_ready = 1'b1; in_valid = 1'b1; in_insn = addi_i;
        tick(); in_valid = 1'b0;
        chk("addi_valid", 32'(out_valid), 1);  chk("addi_ctrl", 32'(out_ctrl), 32'h24);
        chk("addi_rd", 32'(out_rd), 1);        chk("addi_rs", 32'(out_rs), 2);
        chk("addi_imm", out_imm, 5);
        tick();

        // Vector table, streamed back to back
        for (int k = 0; k < 11; k++) begin
            in_valid = 1'b1; in_insn = vecs[k].insn;
            tick();
            chk($sformatf("vec%0d_valid", k), 32'(out_valid), 1);
            chk($sformatf("vec%0d_ctrl", k), 32'(out_ctrl), 32'(vecs[k].ctrl));
            chk($sformatf("vec%0d_aluop", k), 32'(out_alu_op), 32'(vecs[k].alu_op));
            chk($sformatf("vec%0d_ill", k), 32'(out_illegal), 32'(vecs[k].illegal));
        end
        chk_out("vec_last", vecs[10].insn);
        in_valid = 1'b0; tick();

        // Load-use: lw r3 then add reading r3
        in_valid = 1'b1; in_insn = lw_r3;
        tick();
        chk("lu_lw_ctrl", 32'(out_ctrl), 32'h25);
        in_insn = add_r3; #1;
        chk("lu_in_ready_hz", 32'(in_ready), 32'(!HZ_EN));
        tick();
        chk("lu_bubble_valid", 32'(out_valid), 32'(!HZ_EN));
        #1; chk("lu_in_ready_after", 32'(in_ready), 1);
        tick(); in_valid = 1'b0;
        chk("lu_add_valid", 32'(out_valid), 1); chk("lu_add_ctrl", 32'(out_ctrl), 32'h04);
        chk("lu_add_rd", 32'(out_rd), 4);
        tick();

        // Load to r0 never creates a hazard
        in_valid = 1'b1; in_insn = lw_r0;
        tick();
        in_insn = add_r0; #1;
        chk("r0_in_ready", 32'(in_ready), 1);
        tick(); in_valid = 1'b0;
        chk("r0_valid", 32'(out_valid), 1); chk("r0_ctrl", 32'(out_ctrl), 32'h04);
        tick();

        // Back-pressure on a held sw
        in_valid = 1'b1; in_insn = sw_i;
        tick();
        out_ready = 1'b0; in_insn = addi_i;
        for (int k = 0; k < 3; k++) begin
            #1; chk($sformatf("bp%0d_in_ready", k), 32'(in_ready), 0);
            tick();
            chk($sformatf("bp%0d_valid", k), 32'(out_valid), 1);
            chk($sformatf("bp%0d_ctrl", k), 32'(out_ctrl), 32'h28);
            chk($sformatf("bp%0d_rd", k), 32'(out_rd), 6);
            chk($sformatf("bp%0d_imm", k), out_imm, 32'h10);
        end
        out_ready = 1'b1; in_valid = 1'b0; tick();

        // Flush during the bubble drops the waiting add
        in_valid = 1'b1; in_insn = lw_r3;
        tick();
        in_insn = add_r3;
        tick();
        flush = 1'b1; #1;
        chk("fl_in_ready", 32'(in_ready), 1);
        tick(); flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 32'(out_valid), 0);
        #1; chk("fl_in_ready_run", 32'(in_ready), 1);
        tick();
        chk("fl_dropped", 32'(out_valid), 0);

        // Illegal opcode
        in_valid = 1'b1; in_insn = mk(31, 2, 2, 2, 9 << 2);
        tick(); in_valid = 1'b0;
        chk("ill_flag", 32'(out_illegal), 1); chk("ill_ctrl", 32'(out_ctrl), 0);
        chk("ill_aluop", 32'(out_alu_op), 0);
        tick(); tick();

        // Randomized run against the reference model
        m_valid = 1'b0; m_insn = '0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_insn   = gen();
            #1;
            hz = HZ_EN && m_valid && (m_insn[31:27] == 5'd8) && in_valid
                 && m_reads(in_insn, m_insn[26:22]);
            exp_rdy = flush || ((out_ready || !m_valid) && !hz);
            chk("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (flush) m_valid = 1'b0;
            else if (in_valid && exp_rdy) begin m_valid = 1'b1; m_insn = in_insn; end
            else if (m_valid && out_ready) m_valid = 1'b0;
            tick();
            chk("rand_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) chk_out("rand", m_insn);
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_decode_stage.md
# insn_decode_stage

Registered, handshaked instruction decode stage that succeeds the purely combinational opcode decoder. It decodes the full base opcode set into the 8-bit control vector and extracts register fields and immediates. It holds the result in a pipeline register with valid/ready flow control and inserts a one-cycle bubble on load-use hazards. The stage sits between the fetch/IF-ID register and the execute stage of the pipelined processor.

## Interface
- INSN_W, 32, instruction width; the field positions below are fixed for 32.
- DATA_W, 32, width of the sign-extended immediate and the zero-extended jump target.
- REG_AW, 5, register address width.
- RZERO_SKIP, 1, when 1, hazard compares ignore register 0.

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_insn  in  INSN_W  instruction word from fetch
- in_valid  in  1  in_insn is valid
- in_ready  out  1  stage accepts in_insn this cycle
- flush  in  1  synchronous kill of the held and incoming instruction (branch/jump taken)
- out_valid  out  1  decoded outputs are valid
- out_ready  in  1  execute accepts the outputs
- out_ctrl  out  8  {BR, JP, ALUinB, ALUop, DMwe, Rwe, Rdst, Rwd}
- out_alu_op  out  5  ALU operation
- out_shamt  out  5  shift amount
- out_rd, out_rs, out_rt  out  REG_AW  register fields
- out_imm  out  DATA_W  sign-extended insn[16:0]
- out_target  out  DATA_W  zero-extended insn[26:0]
- out_illegal  out  1  undefined opcode

## Operation
- Instruction fields:
  - opcode = insn[31:27], rd = [26:22], rs = [21:17], rt = [16:12].
  - shamt = [11:7], aluop = [6:2].
- Opcode decode (anything else sets illegal = 1 with ctrl = 0):
  - 00000 R-type: Rwe=1; alu_op = aluop.
  - 00001 j: JP=1.
  - 00010 bne: BR=1, ALUop=1; alu_op = 00001.
  - 00011 jal: JP=1, Rwe=1, Rdst=1 (destination r31).
  - 00100 jr: JP=1.
  - 00101 addi: ALUinB=1, Rwe=1.
  - 00110 blt: BR=1, ALUop=1; alu_op = 00001.
  - 00111 sw: ALUinB=1, DMwe=1.
  - 01000 lw: ALUinB=1, Rwe=1, Rwd=1.
- alu_op is 00000 for every opcode not listed with an explicit value.
- Source registers read by each opcode:
  - R-type: rs, rt.
  - addi, lw: rs.
  - sw, bne, blt: rd, rs.
  - jr: rd.
  - j, jal, illegal: none.
- Load-use hazard:
  - Condition: the output register holds a valid lw, and the incoming valid instruction reads a source equal to that lw's rd.
  - When RZERO_SKIP=1, a source equal to 0 never matches.
- State (2 states):
  - RUN: normal flow. Go to BUBBLE when the held lw is accepted downstream (out_valid & out_ready) while the hazard is present. On that edge the output register loads a bubble (out_valid=0) and the incoming instruction is not taken.
  - BUBBLE: lasts exactly one cycle. in_ready = (out_ready | ~out_valid), and the waiting instruction loads normally. Return to RUN unconditionally.
- in_ready in RUN = (out_ready | ~out_valid) & ~hazard.
- Output register update:
  - Loads on in_valid & in_ready.
  - Clears out_valid on out_valid & out_ready & ~(in_valid & in_ready).
  - Otherwise holds every output stable, even while out_ready=0.
- flush (priority over all loads and over the state transition):
  - Next cycle out_valid=0 and state=RUN.
  - The instruction presented in the same cycle is dropped; in_ready is 1 during flush.

## Timing
- Latency: 1 cycle from in_valid & in_ready to out_valid.
- Throughput: 1 instruction per cycle without hazards; a load-use pair costs exactly one bubble cycle.
- Reset:
  - out_valid=0, out_ctrl=0, out_alu_op=0, out_shamt=0, out_rd/rs/rt=0, out_imm=0, out_target=0, out_illegal=0.
  - State=RUN; in_ready=1 in the first cycle after reset.
- A reset mid-bubble returns the stage to RUN and discards the waiting instruction.
- Back-pressure: with out_ready=0 and out_valid=1, in_ready=0 and all outputs hold.
- A hazard against a held lw that is stalled by out_ready=0 does not insert a bubble until that lw is accepted.

## Configuration
- DECODER_HAZARD_EN defined: load-use detection and the BUBBLE state are present.
- DECODER_HAZARD_EN undefined:
  - The hazard term is tied to 0 and no BUBBLE state exists.
  - in_ready = out_ready | ~out_valid.
  - Forwarding or stalling becomes the responsibility of execute.

## Test plan
- Reset: hold reset 2 cycles, then release -> every output is 0 and in_ready=1.
- Single decode:
  - addi 0x28440005 (rd=1, rs=2, imm=5) -> one cycle later out_valid=1.
  - out_ctrl=0x24, out_rd=1, out_rs=2, out_imm=5.
- Load-use hazard, with DECODER_HAZARD_EN and out_ready=1:
  - Feed lw r3,0(r2) then add r4,r3,r5.
  - Required: the lw is emitted (ctrl=0x25), then one cycle with out_valid=0, then the add is emitted (ctrl=0x04).
- Hazard to r0 with RZERO_SKIP=1: lw r0 then an add reading r0 -> no bubble.
- Back-pressure: out_ready=0 for 3 cycles with a held sw -> outputs stable, in_ready=0, ctrl=0x28 throughout.
- Flush and illegal opcode:
  - flush asserted during BUBBLE -> next cycle out_valid=0, state RUN, waiting add dropped.
  - Opcode 11111 -> out_illegal=1, out_ctrl=0.
